// File: rtl/hw_cpu_oci_dct_packer.sv
//============================================================================
// Module   : hw_cpu_oci_dct_packer
// Brief    : Packs 3-bit trace symbols into 10-symbol (30-bit) frames with
//            flush, end-of-test drain and a one-deep output holding register.
//            Optional stall counter enabled by HW_CPU_OCI_DCT_OVFL_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module hw_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [2:0]  sym_data,
  output logic        sym_ready,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        dct_ready,
  output logic        dct_valid,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
`ifdef HW_CPU_OCI_DCT_OVFL_EN
  ,
  output logic [7:0]  overflow_cnt
`endif
);

  localparam logic [3:0] C_FRAME_SYMS = 4'd10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } state_t;

  state_t      r_state;
  logic [29:0] r_acc;
  logic [3:0]  r_acc_cnt;
  logic        r_flush_pend;
  logic        r_live;

  logic        w_accept;
  logic [29:0] w_sym_shift;
  logic [29:0] w_acc_next;
  logic [3:0]  w_acc_cnt_next;
  logic [3:0]  w_cnt_after;
  logic        w_out_free;
  logic        w_launch;
  logic        w_flush_req;
  logic        w_valid_next;
  state_t      w_state_next;

  // r_live keeps sym_ready low until the first edge after reset releases.
  assign sym_ready   = r_live && (r_state == ST_RUN) && (r_acc_cnt < C_FRAME_SYMS);
  assign w_accept    = sym_valid && sym_ready;

  assign w_sym_shift    = 30'(sym_data) << (5'd3 * {1'b0, r_acc_cnt});
  assign w_acc_next     = w_accept ? (r_acc | w_sym_shift) : r_acc;
  assign w_acc_cnt_next = r_acc_cnt + {3'd0, w_accept};

  assign w_out_free   = !dct_valid || dct_ready;
  assign w_launch     = ((w_acc_cnt_next == C_FRAME_SYMS) ||
                         (r_flush_pend && (w_acc_cnt_next != 4'd0))) && w_out_free;
  assign w_flush_req  = (flush || test_ending) && (r_state != ST_ENDED);
  assign w_valid_next = w_launch || (dct_valid && !dct_ready);
  assign w_cnt_after  = w_launch ? 4'd0 : w_acc_cnt_next;

  // Drain completes on the edge that leaves both accumulator and output empty.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (test_ending) w_state_next = ST_DRAIN;
      ST_DRAIN: if ((w_cnt_after == 4'd0) && !w_valid_next) w_state_next = ST_ENDED;
      ST_ENDED: w_state_next = ST_ENDED;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_RUN;
      r_live         <= 1'b0;
      r_acc          <= 30'd0;
      r_acc_cnt      <= 4'd0;
      r_flush_pend   <= 1'b0;
      dct_valid      <= 1'b0;
      dct_buffer     <= 30'd0;
      dct_count      <= 4'd0;
      test_has_ended <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_live         <= 1'b1;
      test_has_ended <= (w_state_next == ST_ENDED);
      dct_valid      <= w_valid_next;

      if (w_launch) begin
        dct_buffer <= w_acc_next;
        dct_count  <= w_acc_cnt_next;
        r_acc      <= 30'd0;
        r_acc_cnt  <= 4'd0;
      end else begin
        r_acc      <= w_acc_next;
        r_acc_cnt  <= w_acc_cnt_next;
      end

      // An empty accumulator swallows the flush so no zero-length frame is sent.
      if (w_launch || (w_acc_cnt_next == 4'd0))
        r_flush_pend <= 1'b0;
      else if (w_flush_req)
        r_flush_pend <= 1'b1;
    end
  end

`ifdef HW_CPU_OCI_DCT_OVFL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow_cnt <= 8'd0;
    else if (sym_valid && !sym_ready && (overflow_cnt != 8'hFF))
      overflow_cnt <= overflow_cnt + 8'd1;
  end
`endif

endmodule

`default_nettype wire

// File: doc/hw_cpu_oci_dct_packer.md
HW_CPU_OCI_DCT_PACKER -- requirements
Module: hw_cpu_oci_dct_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, reset input 1.
REQ-002 sym_valid input 1: a trace symbol is offered on this cycle.
REQ-003 sym_data input 3: the trace symbol value.
REQ-004 sym_ready output 1: the block accepts sym_data on any cycle where sym_valid and sym_ready are both 1.
REQ-005 flush input 1: a single-cycle request to emit a partial frame.
REQ-006 test_ending input 1: a single-cycle request to end the capture.
REQ-007 dct_ready input 1: the downstream consumer accepts the current frame.
REQ-008 dct_valid output 1: a frame is held on dct_buffer and dct_count.
REQ-009 dct_buffer output 30: the packed symbols.
REQ-010 dct_count output 4: the number of valid symbols in the frame, 1..10.
REQ-011 test_has_ended output 1: capture finished and fully drained.
REQ-012 overflow_cnt output 8: stall counter; present only with HW_CPU_OCI_DCT_OVFL_EN.

Function
REQ-013 The accumulator SHALL place accepted symbol number i (0-based, i = acc_cnt) at dct_buffer bits [3i+2:3i]; bits above the last valid symbol SHALL be 0.
REQ-014 sym_ready SHALL equal 1 only when state is RUN and acc_cnt < 10.
REQ-015 "Launch" means the block copies the post-accept accumulator into the output register, sets dct_valid, and clears the accumulator to 0 in the same edge.
- Launch condition: (acc_cnt_next == 10, or flush_pend and acc_cnt_next > 0) and out_free.
- out_free = !dct_valid or dct_ready.
REQ-016 Latency: when the 10th symbol is accepted at edge N with out_free, dct_valid SHALL be 1 after edge N, with dct_count = 10.
REQ-017 While dct_valid = 1 and dct_ready = 0, dct_buffer and dct_count SHALL hold stable.
REQ-018 A handshake and a new launch in the same cycle SHALL replace the frame with no bubble.
REQ-019 When a handshake occurs with no launch, dct_valid SHALL clear on the next edge.
REQ-020 flush or test_ending SHALL set flush_pend.
- flush_pend SHALL clear on launch.
- flush_pend SHALL also clear when acc_cnt_next == 0; a flush with an empty accumulator emits no frame.
REQ-021 A symbol accepted in the same cycle as flush SHALL be included in the flushed frame.
REQ-022 State machine: RUN -> DRAIN on test_ending; DRAIN -> ENDED when acc_cnt == 0 and dct_valid == 0 (after the edge); ENDED is terminal until reset.
REQ-023 In DRAIN and ENDED, sym_ready SHALL be 0; flush and test_ending SHALL be ignored in ENDED.
REQ-024 test_has_ended SHALL be 1 exactly while the state is ENDED.
REQ-025 With the accumulator full (acc_cnt == 10) and the output blocked, the block SHALL hold both frames and keep sym_ready = 0; no symbol is ever lost.

Reset
REQ-026 Asserting reset SHALL asynchronously force the following values, even mid-frame or mid-drain:
- state = RUN
- acc_cnt = 0, accumulator = 0, flush_pend = 0
- dct_valid = 0, dct_buffer = 0, dct_count = 0
- test_has_ended = 0, overflow_cnt = 0
REQ-027 sym_ready SHALL be 1 from the first clk edge after reset deasserts.

Configuration
REQ-028 With HW_CPU_OCI_DCT_OVFL_EN defined:
- overflow_cnt SHALL increment once per cycle where sym_valid = 1 and sym_ready = 0.
- overflow_cnt SHALL saturate at 255.
REQ-029 Without HW_CPU_OCI_DCT_OVFL_EN defined:
- the overflow_cnt port and its counter SHALL be absent.
- All other behaviour SHALL be identical.

Verification
REQ-030 Full frame: 10 symbols 0..7,0,1 back-to-back with dct_ready = 1 -> one frame, dct_count = 10, dct_buffer = 30'h0_8FAC688 (symbol i at [3i+2:3i]), dct_valid high one cycle after the 10th accept.
REQ-031 Partial flush: 3 symbols 5,3,7, then flush -> dct_count = 3, dct_buffer = 30'h1DD, zeros above bit 8. A flush with an empty accumulator -> no frame.
REQ-032 Backpressure: dct_ready = 0 while 20 symbols are offered -> sym_ready drops after the 20th accept, the first frame is held stable, and draining delivers two 10-count frames in order with no loss. With HW_CPU_OCI_DCT_OVFL_EN, 5 extra stalled cycles -> overflow_cnt = 5.
REQ-033 End of test: 4 symbols, test_ending, dct_ready = 0 for 3 cycles then 1 -> sym_ready = 0 immediately; a frame with dct_count = 4 is delivered; test_has_ended rises the edge after the handshake and stays high.
REQ-034 Reset mid-frame: 6 symbols accepted, then reset pulsed -> all outputs zero, sym_ready = 1 after release, and the next full frame packs from bit 0.
